// File: rtl/truth_table_extractor.sv
// Purpose : reads back the truth table of an N_IN-input, 1-output combinational DUT by driving
//           every minterm, waiting SETTLE_CYC cycles, sampling probe_out and returning the packed table.
// Latency : busy for 2**N_IN*(SETTLE_CYC+1) cycles after start; done pulses in the following cycle.
// Backpressure: none; start is only honoured in IDLE, requests while busy/done are dropped, not queued.
// Ports   : clk, rst_n (async active-low), start -> request extraction;
//           probe_in -> minterm index to DUT (MSB = first DUT input); probe_out <- DUT output;
//           busy (SETTLE/SAMPLE), done (1-cycle pulse), table_out (bit i = output for minterm i).
// Optional: define TT_CHECK_EN to add expected_tt (in), mismatch and mismatch_map (out) golden compare.
module truth_table_extractor #(
   parameter int N_IN       = 2,
   parameter int SETTLE_CYC = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic [N_IN-1:0]        probe_in,
   input  logic                   probe_out,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   table_out
`ifdef TT_CHECK_EN
   ,
   input  logic [(1<<N_IN)-1:0]   expected_tt,
   output logic                   mismatch,
   output logic [(1<<N_IN)-1:0]   mismatch_map
`endif
);

   localparam int TW = 1 << N_IN;
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [N_IN:0]  IDX_LAST = (N_IN+1)'(TW - 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t          state;
   state_t          next_state;
   logic [N_IN:0]   idx;
   logic [CW-1:0]   cnt;
   logic [TW-1:0]   work;
   logic [TW-1:0]   final_tt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:   if (start) next_state = SETTLE;
         SETTLE: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) next_state = SAMPLE;
         end
         SAMPLE: begin
            busy       = 1'b1;
            next_state = (idx == IDX_LAST) ? DONE : SETTLE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Probe is only driven while a minterm is active; parked at 0 in IDLE/DONE.
   assign probe_in = busy ? idx[N_IN-1:0] : '0;

   // Work table with the current sample merged in. Loading table_out from this on the
   // final SAMPLE edge makes the complete table visible in the same cycle done is high,
   // and table_out never carries a partially filled table.
   always_comb begin
      final_tt                    = work;
      final_tt[idx[N_IN-1:0]]     = probe_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         cnt          <= '0;
         work         <= '0;
         table_out    <= '0;
`ifdef TT_CHECK_EN
         mismatch     <= 1'b0;
         mismatch_map <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx <= '0;
                  cnt <= '0;
               end
            end
            SETTLE: begin
               if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
            end
            SAMPLE: begin
               work <= final_tt;
               if (idx == IDX_LAST) begin
                  table_out    <= final_tt;
`ifdef TT_CHECK_EN
                  // Golden table must be stable by the final SAMPLE cycle; result is
                  // valid alongside table_out for the whole DONE cycle and after.
                  mismatch_map <= final_tt ^ expected_tt;
                  mismatch     <= |(final_tt ^ expected_tt);
`endif
               end else begin
                  idx <= idx + 1'b1;
                  cnt <= '0;
               end
            end
            DONE: begin
               idx <= '0;
               cnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_extractor.sv
// Bench for truth_table_extractor: a 2-input instance (SETTLE_CYC=2) and a 3-input instance
// (SETTLE_CYC=1), each wired to a behavioural combinational DUT selected by a function code.
module tb_truth_table_extractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- instance A: N_IN=2, SETTLE_CYC=2 ----------------
   logic       start_a = 1'b0;
   logic [1:0] probe_in_a;
   logic       probe_out_a;
   logic       busy_a, done_a;
   logic [3:0] table_a;
   int         code_a = 0;
   logic [3:0] rnd_a  = 4'h0;
`ifdef TT_CHECK_EN
   logic [3:0] expected_tt_a = 4'b1010;
   logic       mismatch_a;
   logic [3:0] mismatch_map_a;
`endif

   truth_table_extractor #(.N_IN(2), .SETTLE_CYC(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .probe_in(probe_in_a), .probe_out(probe_out_a),
      .busy(busy_a), .done(done_a), .table_out(table_a)
`ifdef TT_CHECK_EN
      , .expected_tt(expected_tt_a), .mismatch(mismatch_a), .mismatch_map(mismatch_map_a)
`endif
   );

   // ---------------- instance B: N_IN=3, SETTLE_CYC=1 ----------------
   logic       start_b = 1'b0;
   logic [2:0] probe_in_b;
   logic       probe_out_b;
   logic       busy_b, done_b;
   logic [7:0] table_b;
   int         code_b = 0;
   logic [7:0] rnd_b  = 8'h00;
`ifdef TT_CHECK_EN
   logic [7:0] expected_tt_b = 8'h00;
   logic       mismatch_b;
   logic [7:0] mismatch_map_b;
`endif

   truth_table_extractor #(.N_IN(3), .SETTLE_CYC(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .probe_in(probe_in_b), .probe_out(probe_out_b),
      .busy(busy_b), .done(done_b), .table_out(table_b)
`ifdef TT_CHECK_EN
      , .expected_tt(expected_tt_b), .mismatch(mismatch_b), .mismatch_map(mismatch_map_b)
`endif
   );

   // ---------------- behavioural DUTs and reference model ----------------
   // x[1] is the first DUT input (MSB), x[0] the second.
   function automatic logic gate2(int code, logic [3:0] rt, logic [1:0] x);
      case (code)
         0:       return x[0];            // second input
         1:       return x[1] & x[0];     // AND
         2:       return x[1] | x[0];     // OR
         3:       return x[1] ^ x[0];     // XOR
         4:       return x[0];            // buffer of second input
         default: return rt[x];           // arbitrary table
      endcase
   endfunction

   function automatic logic gate3(int code, logic [7:0] rt, logic [2:0] x);
      if (code == 0) return (int'(x[2]) + int'(x[1]) + int'(x[0])) >= 2;   // majority
      return rt[x];
   endfunction

   // Expected table: evaluate the function at every minterm index.
   function automatic logic [3:0] ref_tt2(int code, logic [3:0] rt);
      logic [3:0] t;
      for (int i = 0; i < 4; i++) t[i] = gate2(code, rt, 2'(i));
      return t;
   endfunction

   function automatic logic [7:0] ref_tt3(int code, logic [7:0] rt);
      logic [7:0] t;
      for (int i = 0; i < 8; i++) t[i] = gate3(code, rt, 3'(i));
      return t;
   endfunction

   always_comb probe_out_a = gate2(code_a, rnd_a, probe_in_a);
   always_comb probe_out_b = gate3(code_b, rnd_b, probe_in_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // One extraction on instance A; optional random start pulses while busy.
   task automatic run_a(input string name, input int code, input logic [3:0] exp, input bit extra);
      int bcnt = 0;
      int guard = 0;
      code_a  = code;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      while (!done_a && guard < 300) begin
         if (busy_a) bcnt++;
         start_a = extra && ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
         guard++;
      end
      start_a = 1'b0;
      if (guard >= 300) chk({name, "_timeout"}, 1, 0);
      chk({name, "_busy_cycles"}, bcnt, 12);
      chk({name, "_table"}, 32'(table_a), 32'(exp));
      chk({name, "_busy_in_done"}, 32'(busy_a), 0);
      chk({name, "_probe_in_done"}, 32'(probe_in_a), 0);
`ifdef TT_CHECK_EN
      chk({name, "_mismatch_map"}, 32'(mismatch_map_a), 32'(exp ^ expected_tt_a));
      chk({name, "_mismatch"}, 32'(mismatch_a), 32'(exp != expected_tt_a));
`endif
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, 32'(done_a), 0);
      @(posedge clk); #1;
      chk({name, "_no_queued_start"}, 32'(busy_a), 0);
      chk({name, "_table_held"}, 32'(table_a), 32'(exp));
   endtask

   task automatic run_b(input string name, input int code, input logic [7:0] exp);
      int bcnt = 0;
      int guard = 0;
      code_b  = code;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      while (!done_b && guard < 300) begin
         if (busy_b) bcnt++;
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 300) chk({name, "_timeout"}, 1, 0);
      chk({name, "_busy_cycles"}, bcnt, 16);
      chk({name, "_table"}, 32'(table_b), 32'(exp));
`ifdef TT_CHECK_EN
      chk({name, "_mismatch_map"}, 32'(mismatch_map_b), 32'(exp ^ expected_tt_b));
`endif
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, 32'(done_b), 0);
   endtask

   typedef struct {
      string      name;
      int         code;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{"second_input", 0, 4'b1010};
      vecs[1] = '{"and",          1, 4'b1000};
      vecs[2] = '{"or",           2, 4'b1110};
      vecs[3] = '{"xor",          3, 4'b0110};
      vecs[4] = '{"buffer",       4, 4'b1010};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",     32'(busy_a), 0);
      chk("rst_done",     32'(done_a), 0);
      chk("rst_table",    32'(table_a), 0);
      chk("rst_probe_in", 32'(probe_in_a), 0);
      chk("rst_table_b",  32'(table_b), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fixed gate functions
      for (int v = 0; v < 5; v++) run_a(vecs[v].name, vecs[v].code, vecs[v].exp, 1'b0);

      // Randomized functions with random start pulses mid-run
      for (int r = 0; r < 12; r++) begin
         int c;
         c     = $urandom_range(0, 5);
         rnd_a = 4'($urandom);
         run_a("random", c, ref_tt2(c, rnd_a), 1'b1);
      end

      // start held high: back-to-back runs, 14-cycle period, one IDLE cycle between
      begin
         int bc = 0;
         int dc = 0;
         code_a  = 0;
         start_a = 1'b1;
         for (int k = 0; k < 42; k++) begin
            @(posedge clk); #1;
            if (busy_a) bc++;
            if (done_a) begin
               dc++;
               chk("held_table", 32'(table_a), 32'(ref_tt2(0, 4'h0)));
               chk("held_busy_cycles_so_far", bc, dc * 12);
            end
         end
         start_a = 1'b0;
         chk("held_busy_total", bc, 36);
         chk("held_done_total", dc, 3);
         @(posedge clk); #1;
         chk("held_stop_idle", 32'(busy_a), 0);
      end

      // Reset during minterm 2 SETTLE
      run_a("pre_reset_or", 2, ref_tt2(2, 4'h0), 1'b0);
      begin
         int guard = 0;
         int dseen = 0;
         code_a  = 3;
         start_a = 1'b1;
         @(posedge clk); #1;
         start_a = 1'b0;
         while (probe_in_a != 2'd2 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 100) chk("rst_mid_reach_m2", 1, 0);
         #2;
         rst_n = 1'b0;
         #1;
         chk("rst_mid_busy",     32'(busy_a), 0);
         chk("rst_mid_done",     32'(done_a), 0);
         chk("rst_mid_table",    32'(table_a), 0);
         chk("rst_mid_probe_in", 32'(probe_in_a), 0);
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done_a) dseen++;
         end
         rst_n = 1'b1;
         for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done_a) dseen++;
         end
         chk("rst_mid_no_done", dseen, 0);
         run_a("post_reset_xor", 3, ref_tt2(3, 4'h0), 1'b0);
      end

      // 3-input instance: majority then random tables
      run_b("majority", 0, 8'b1110_1000);
      chk("majority_model", 32'(ref_tt3(0, 8'h00)), 32'(8'b1110_1000));
      for (int r = 0; r < 4; r++) begin
         rnd_b = 8'($urandom);
         run_b("random3", 1, ref_tt3(1, rnd_b));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
